// File: rtl/nn_pkg.sv
// Shared defaults and FSM state encoding for the NN feature sequencer.
package nn_pkg;

  localparam int NN_DATA_W_DEF = 17;
  localparam int NN_N_FEAT_DEF = 7;
  localparam int NN_LAT_DEF    = 4;
  localparam int NN_CNT_W      = 3;
  localparam int NN_CLAMP_LSB  = 12;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    RUN  = 2'd1,
    OUT  = 2'd2
  } nn_state_e;

endpackage

// File: rtl/nn_feature_sequencer_if.sv
// Feature-in / result-out stream bundle; the sequencer is the slave side of both.
interface nn_feature_sequencer_if #(
  parameter int DATA_W = nn_pkg::NN_DATA_W_DEF
) ();

  logic [DATA_W-1:0] s_data;
  logic              s_valid;
  logic              s_last;
  logic              s_ready;
  logic [DATA_W-1:0] m_data;
  logic              m_valid;
  logic              m_ready;

  modport slave (
    input  s_data, s_valid, s_last, m_ready,
    output s_ready, m_data, m_valid
  );

  modport master (
    output s_data, s_valid, s_last, m_ready,
    input  s_ready, m_data, m_valid
  );

endinterface

// File: rtl/nn_feat_shreg.sv
// N_FEAT x DATA_W feature capture register, written at a self-advancing index.
module nn_feat_shreg
  import nn_pkg::*;
#(
  parameter int DATA_W = NN_DATA_W_DEF,
  parameter int N_FEAT = NN_N_FEAT_DEF
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       wr_en_i,
  input  logic                       idx_clr_i,
  input  logic [DATA_W-1:0]          wr_data_i,
  output logic [$clog2(N_FEAT)-1:0]  idx_o,
  output logic [DATA_W-1:0]          feat_o [N_FEAT]
);

  localparam int IDX_W = $clog2(N_FEAT);

  logic [IDX_W-1:0]  idx_q;
  logic [IDX_W-1:0]  idx_d;
  logic [DATA_W-1:0] feat_q [N_FEAT];

  // Index restarts on a completed or dropped vector, otherwise advances per word.
  always_comb begin
    idx_d = idx_q;
    if (wr_en_i) begin
      idx_d = idx_clr_i ? '0 : idx_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      idx_q <= '0;
      for (int i = 0; i < N_FEAT; i++) begin
        feat_q[i] <= '0;
      end
    end else begin
      idx_q <= idx_d;
      for (int i = 0; i < N_FEAT; i++) begin
        if (wr_en_i && (idx_q == IDX_W'(i))) begin
          feat_q[i] <= wr_data_i;
        end
      end
    end
  end

  assign idx_o  = idx_q;
  assign feat_o = feat_q;

endmodule

// File: rtl/nn_feature_sequencer.sv
// Loads a feature vector, clocks the network for NN_LAT cycles, hands off the result.
// Optional build macro NN_SEQ_CLAMP_EN saturates wide input words to 12'hFFF on capture.
module nn_feature_sequencer
  import nn_pkg::*;
#(
  parameter int DATA_W = NN_DATA_W_DEF,
  parameter int N_FEAT = NN_N_FEAT_DEF,
  parameter int NN_LAT = NN_LAT_DEF
) (
  input  logic                clk,
  input  logic                rst_n,
  nn_feature_sequencer_if.slave bus,
  output logic [DATA_W-1:0]   nn_x1,
  output logic [DATA_W-1:0]   nn_x2,
  output logic [DATA_W-1:0]   nn_x3,
  output logic [DATA_W-1:0]   nn_x4,
  output logic [DATA_W-1:0]   nn_x5,
  output logic [DATA_W-1:0]   nn_x6,
  output logic [DATA_W-1:0]   nn_x7,
  output logic                nn_ce,
  input  logic [DATA_W-1:0]   nn_y,
  output logic                frame_err
);

  localparam int                 IDX_W    = $clog2(N_FEAT);
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(N_FEAT - 1);
  localparam logic [NN_CNT_W-1:0] CNT_LAST = NN_CNT_W'(NN_LAT - 1);

  nn_state_e           state_q;
  logic [NN_CNT_W-1:0] cnt_q;
  logic                nn_ce_q;
  logic                m_valid_q;
  logic                frame_err_q;
  logic [DATA_W-1:0]   m_data_q;

  logic [IDX_W-1:0]    idx;
  logic [DATA_W-1:0]   feat [N_FEAT];
  logic [DATA_W-1:0]   word_d;
  logic                s_ready;
  logic                accept;
  logic                at_last;
  logic                vec_done;
  logic                vec_err;

`ifdef NN_SEQ_CLAMP_EN
  localparam logic [DATA_W-1:0] CLAMP_VAL =
    {{(DATA_W - NN_CLAMP_LSB){1'b0}}, {NN_CLAMP_LSB{1'b1}}};

  function automatic logic [DATA_W-1:0] clamp_word(input logic [DATA_W-1:0] w);
    return (|w[DATA_W-1:NN_CLAMP_LSB]) ? CLAMP_VAL : w;
  endfunction

  assign word_d = clamp_word(bus.s_data);
`else
  assign word_d = bus.s_data;
`endif

  // Ready is gated by rst_n so nothing is accepted while reset is held.
  assign s_ready  = rst_n && (state_q == LOAD);
  assign accept   = bus.s_valid && s_ready;
  assign at_last  = (idx == IDX_LAST);
  assign vec_done = accept && bus.s_last && at_last;
  assign vec_err  = accept && (bus.s_last != at_last);

  nn_feat_shreg #(
    .DATA_W (DATA_W),
    .N_FEAT (N_FEAT)
  ) u_shreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .wr_en_i   (accept),
    .idx_clr_i (bus.s_last || at_last),
    .wr_data_i (word_d),
    .idx_o     (idx),
    .feat_o    (feat)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      cnt_q       <= '0;
      nn_ce_q     <= 1'b0;
      m_valid_q   <= 1'b0;
      frame_err_q <= 1'b0;
      m_data_q    <= '0;
    end else begin
      frame_err_q <= 1'b0;
      unique case (state_q)
        LOAD: begin
          if (vec_err) begin
            frame_err_q <= 1'b1;
          end else if (vec_done) begin
            state_q <= RUN;
            nn_ce_q <= 1'b1;
            cnt_q   <= '0;
          end
        end
        RUN: begin
          // Result is captured on the final enabled cycle, so nn_y is sampled while nn_ce is still high.
          if (cnt_q == CNT_LAST) begin
            m_data_q  <= nn_y;
            m_valid_q <= 1'b1;
            nn_ce_q   <= 1'b0;
            state_q   <= OUT;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        OUT: begin
          if (bus.m_ready) begin
            m_valid_q <= 1'b0;
            state_q   <= LOAD;
          end
        end
        default: begin
          state_q <= LOAD;
          nn_ce_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_ready = s_ready;
  assign bus.m_data  = m_data_q;
  assign bus.m_valid = m_valid_q;
  assign nn_ce       = nn_ce_q;
  assign frame_err   = frame_err_q;

  assign nn_x1 = feat[0];
  assign nn_x2 = feat[1];
  assign nn_x3 = feat[2];
  assign nn_x4 = feat[3];
  assign nn_x5 = feat[4];
  assign nn_x6 = feat[5];
  assign nn_x7 = feat[6];

endmodule

// File: tb/tb_nn_feature_sequencer.sv
// Directed bench for nn_feature_sequencer with a result scoreboard and a negedge monitor.
module tb_nn_feature_sequencer;

  localparam int DW = 17;

  logic          clk;
  logic          rst_n;
  logic [DW-1:0] nn_x1, nn_x2, nn_x3, nn_x4, nn_x5, nn_x6, nn_x7;
  logic          nn_ce;
  logic [DW-1:0] nn_y;
  logic          frame_err;

  nn_feature_sequencer_if #(.DATA_W(DW)) bus_if ();

  nn_feature_sequencer #(.DATA_W(DW), .N_FEAT(7), .NN_LAT(4)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .bus       (bus_if),
    .nn_x1     (nn_x1),
    .nn_x2     (nn_x2),
    .nn_x3     (nn_x3),
    .nn_x4     (nn_x4),
    .nn_x5     (nn_x5),
    .nn_x6     (nn_x6),
    .nn_x7     (nn_x7),
    .nn_ce     (nn_ce),
    .nn_y      (nn_y),
    .frame_err (frame_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            n_cmp = 0;
  int            n_err = 0;
  int            cyc = 0;
  int            ce_count = 0;
  int            fe_count = 0;
  int            mv_rises = 0;
  int            n_pop = 0;
  int            xfer_cyc = 0;
  bit            nn_mode = 1'b0;
  bit            mv_prev = 1'b0;
  logic [DW-1:0] fixed_y = '0;
  logic [DW-1:0] vec   [7];
  logic [DW-1:0] exp_x [7];
  logic [DW-1:0] sb    [$];

  // Network stand-in: XOR of the operands (or a fixed value), only driven while enabled.
  assign nn_y = !nn_ce ? '0 :
                nn_mode ? (nn_x1 ^ nn_x2 ^ nn_x3 ^ nn_x4 ^ nn_x5 ^ nn_x6 ^ nn_x7) : fixed_y;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [DW-1:0] exp_store(input logic [DW-1:0] w);
`ifdef NN_SEQ_CLAMP_EN
    return (w[16:12] != 5'd0) ? 17'h00FFF : w;
`else
    return w;
`endif
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (nn_ce) begin
        ce_count++;
        chk("nn_x_stable", {nn_x1, nn_x2, nn_x3, nn_x4, nn_x5, nn_x6, nn_x7},
            {exp_x[0], exp_x[1], exp_x[2], exp_x[3], exp_x[4], exp_x[5], exp_x[6]});
      end
      if (nn_ce || bus_if.m_valid) chk("s_ready_busy", bus_if.s_ready, 1'b0);
      if (frame_err) fe_count++;
      if (bus_if.m_valid && !mv_prev) mv_rises++;
      if (bus_if.m_valid && bus_if.m_ready) begin
        chk("sb_depth", sb.size(), 1);
        if (sb.size() > 0) chk("m_data", bus_if.m_data, sb.pop_front());
        n_pop++;
      end
    end
    mv_prev = bus_if.m_valid;
  end

  // Called at posedge+2; leaves s_valid high after the word transfers.
  task automatic send_word(input logic [DW-1:0] d, input logic l);
    int w;
    w = 0;
    bus_if.s_valid = 1'b1;
    bus_if.s_data  = d;
    bus_if.s_last  = l;
    @(negedge clk);
    while (!bus_if.s_ready && w < 50) begin
      w++;
      @(negedge clk);
    end
    if (!bus_if.s_ready) begin
      chk("s_ready_wait", bus_if.s_ready, 1'b1);
    end else begin
      xfer_cyc = cyc;
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push_expected();
    logic [DW-1:0] y;
    y = '0;
    for (int i = 0; i < 7; i++) begin
      exp_x[i] = exp_store(vec[i]);
      y ^= exp_x[i];
    end
    sb.push_back(nn_mode ? y : fixed_y);
  endtask

  task automatic send_vec(input bit hold);
    for (int i = 0; i < 7; i++) send_word(vec[i], i == 6);
    if (!hold) bus_if.s_valid = 1'b0;
    push_expected();
  endtask

  task automatic wait_mv();
    int w;
    w = 0;
    @(negedge clk);
    while (!bus_if.m_valid && w < 40) begin
      w++;
      @(negedge clk);
    end
    chk("m_valid_seen", bus_if.m_valid, 1'b1);
    chk("latency", cyc - xfer_cyc, 5);
  endtask

  task automatic wait_pop(input int target);
    int w;
    w = 0;
    while (n_pop < target && w < 100) begin
      w++;
      @(negedge clk);
    end
    chk("pop_count", n_pop, target);
  endtask

  task automatic rand_vec();
    for (int i = 0; i < 7; i++) vec[i] = DW'($urandom_range(0, 32'h1FFFF));
  endtask

  initial begin
    int base;
    rst_n = 1'b0;
    bus_if.s_valid = 1'b0;
    bus_if.s_data  = '0;
    bus_if.s_last  = 1'b0;
    bus_if.m_ready = 1'b0;
    for (int i = 0; i < 7; i++) exp_x[i] = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_s_ready", bus_if.s_ready, 1'b0);
    chk("rst_nn_ce", nn_ce, 1'b0);
    chk("rst_m_valid", bus_if.m_valid, 1'b0);
    chk("rst_frame_err", frame_err, 1'b0);
    chk("rst_m_data", bus_if.m_data, 17'h0);
    chk("rst_nn_x", {nn_x1, nn_x2, nn_x3, nn_x4, nn_x5, nn_x6, nn_x7}, 119'h0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    @(negedge clk);
    chk("load_s_ready", bus_if.s_ready, 1'b1);

    // Reference vector with fixed network result, result held back by m_ready=0.
    @(posedge clk); #2;
    nn_mode = 1'b0;
    fixed_y = 17'h00123;
    vec = '{17'h0DED, 17'h0979, 17'h0636, 17'h05A5, 17'h0A8A, 17'h0191, 17'h0373};
    ce_count = 0;
    send_vec(1'b0);
    wait_mv();
    chk("ce_cycles", ce_count, 4);
    repeat (10) begin
      @(negedge clk);
      chk("hold_m_valid", bus_if.m_valid, 1'b1);
      chk("hold_m_data", bus_if.m_data, 17'h00123);
      chk("hold_s_ready", bus_if.s_ready, 1'b0);
    end
    @(posedge clk); #2;
    bus_if.m_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("post_m_valid", bus_if.m_valid, 1'b0);
    chk("post_s_ready", bus_if.s_ready, 1'b1);
    chk("post_pop", n_pop, 1);

    // Early s_last drops the vector; the next full vector still works.
    @(posedge clk); #2;
    nn_mode = 1'b1;
    ce_count = 0;
    fe_count = 0;
    rand_vec();
    send_word(vec[0], 1'b0);
    send_word(vec[1], 1'b0);
    send_word(vec[2], 1'b1);
    bus_if.s_valid = 1'b0;
    @(negedge clk);
    chk("fe_early_pulse", frame_err, 1'b1);
    @(negedge clk);
    chk("fe_early_clear", frame_err, 1'b0);
    repeat (5) @(negedge clk);
    chk("fe_no_ce", ce_count, 0);
    chk("fe_count", fe_count, 1);
    chk("fe_s_ready", bus_if.s_ready, 1'b1);
    @(posedge clk); #2;
    rand_vec();
    send_vec(1'b0);
    wait_mv();
    chk("fe_next_ce", ce_count, 4);
    wait_pop(2);

    // Missing s_last on the seventh word also drops the vector.
    @(posedge clk); #2;
    ce_count = 0;
    rand_vec();
    for (int i = 0; i < 7; i++) send_word(vec[i], 1'b0);
    bus_if.s_valid = 1'b0;
    @(negedge clk);
    chk("fe_late_pulse", frame_err, 1'b1);
    repeat (4) @(negedge clk);
    chk("fe_late_no_ce", ce_count, 0);
    @(posedge clk); #2;
    rand_vec();
    send_vec(1'b0);
    wait_mv();
    wait_pop(3);

    // Reset pulse on the second RUN cycle abandons the vector.
    @(posedge clk); #2;
    rand_vec();
    send_vec(1'b0);
    @(posedge clk); #2;
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_run_s_ready", bus_if.s_ready, 1'b0);
    @(posedge clk); #2;
    rst_n = 1'b1;
    sb.delete();
    @(negedge clk);
    chk("rst_run_nn_ce", nn_ce, 1'b0);
    chk("rst_run_m_valid", bus_if.m_valid, 1'b0);
    chk("rst_run_load", bus_if.s_ready, 1'b1);
    chk("rst_run_nn_x1", nn_x1, 17'h0);
    base = mv_rises;
    repeat (12) @(negedge clk);
    chk("rst_run_no_mv", mv_rises, base);
    chk("rst_run_no_pop", n_pop, 3);

    // Wide-word capture with and without the clamp option.
    @(posedge clk); #2;
    vec = '{17'h1F000, 17'h00FFF, 17'h01000, 17'h10001, 17'h0ABCD, 17'h00000, 17'h1FFFF};
    send_word(vec[0], 1'b0);
    bus_if.s_valid = 1'b0;
    @(negedge clk);
`ifdef NN_SEQ_CLAMP_EN
    chk("clamp_nn_x1", nn_x1, 17'h00FFF);
`else
    chk("clamp_nn_x1", nn_x1, 17'h1F000);
`endif
    @(posedge clk); #2;
    for (int i = 1; i < 7; i++) send_word(vec[i], i == 6);
    bus_if.s_valid = 1'b0;
    push_expected();
    wait_mv();
    wait_pop(4);

    // Back-to-back vectors with s_valid held high across RUN/OUT.
    @(posedge clk); #2;
    rand_vec();
    send_vec(1'b1);
    rand_vec();
    send_vec(1'b0);
    wait_pop(6);
    chk("b2b_sb_empty", sb.size(), 0);

    repeat (5) @(posedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
